ew_threat_gen: RTL and testbench

EW_THREAT_GEN -- requirements
Module: ew_threat_gen

---
 rtl/ew_sim_pkg.sv | 41 ++++
 rtl/ew_lfsr8.sv | 19 +
 rtl/ew_threat_gen.sv | 133 +++++++++++++
 tb/tb_ew_threat_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ew_sim_pkg.sv
// rtl/ew_sim_pkg.sv - shared phase encoding, threat constants and LFSR helpers
package ew_sim_pkg;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_BURST   = 3'd1,
    PH_SPOOF   = 3'd2,
    PH_ENTROPY = 3'd3,
    PH_SWEEP   = 3'd4,
    PH_QUIET   = 3'd5,
    PH_DONE    = 3'd6
  } phase_e;

  localparam logic [7:0] SIG_BURST   = 8'd220;
  localparam logic [7:0] CMD_BURST   = 8'hFF;
  localparam logic [7:0] SIG_SPOOF   = 8'd123;
  localparam logic [7:0] CMD_SPOOF   = 8'h00;
  localparam logic [7:0] CMD_ENTROPY = 8'hAA;
  localparam logic [7:0] CMD_SWEEP   = 8'h55;
  localparam logic [7:0] SIG_IDLE    = 8'h00;
  localparam logic [7:0] CMD_IDLE    = 8'h00;

  // x^8+x^6+x^5+x^4+1 maps to state bits 7,5,4,3 in a shift-left Fibonacci register
  localparam logic [7:0] LFSR_SEED = 8'hE1;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

  // Lowest enabled threat phase whose mask bit is at or above from_bit, else QUIET
  function automatic phase_e next_enabled(input logic [3:0] mask, input logic [2:0] from_bit);
    phase_e r;
    r = PH_QUIET;
    for (int i = 3; i >= 0; i--) begin
      if (i >= int'(from_bit) && mask[i]) r = phase_e'(i[2:0] + 3'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/ew_lfsr8.sv
// rtl/ew_lfsr8.sv - 8-bit Fibonacci LFSR feeding the ENTROPY threat byte
import ew_sim_pkg::*;

module ew_lfsr8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] value
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= LFSR_SEED;
    end else if (enable) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/ew_threat_gen.sv
// rtl/ew_threat_gen.sv - scripted threat scenario player driving the EW core inputs
import ew_sim_pkg::*;

module ew_threat_gen #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         scenario_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               repeat_en,
  input  logic               abort,
  output logic [7:0]         signal_out,
  output logic [7:0]         command_out,
  output logic [2:0]         phase,
  output logic               valid,
  output logic               busy,
  output logic               done
);

  phase_e             cur_ph;
  phase_e             nxt_ph;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [3:0]         cfg_mask;
  logic               cfg_repeat;
  logic               accept;
  logic [DWELL_W-1:0] reload_src;
  logic [DWELL_W-1:0] reload_val;
  logic               lfsr_en;
  logic [7:0]         lfsr_value;

  always_comb begin
    accept = 1'b0;
    nxt_ph = PH_IDLE;
    case (cur_ph)
      PH_IDLE: begin
        if (start && !abort && (scenario_mask != 4'd0)) begin
          accept = 1'b1;
          nxt_ph = next_enabled(scenario_mask, 3'd0);
        end
      end
      PH_BURST, PH_SPOOF, PH_ENTROPY, PH_SWEEP: begin
        if (abort)                    nxt_ph = PH_IDLE;
        else if (dwell_cnt != '0)     nxt_ph = cur_ph;
        // phase code p sits one above its mask bit, so bit p is the next candidate
        else                          nxt_ph = next_enabled(cfg_mask, cur_ph);
      end
      PH_QUIET: begin
        if (abort)                    nxt_ph = PH_IDLE;
        else if (dwell_cnt != '0)     nxt_ph = PH_QUIET;
        else                          nxt_ph = PH_DONE;
      end
      PH_DONE: begin
        if (abort)                    nxt_ph = PH_IDLE;
        else if (cfg_repeat)          nxt_ph = next_enabled(cfg_mask, 3'd0);
        else                          nxt_ph = PH_IDLE;
      end
      default: nxt_ph = PH_IDLE;
    endcase

    reload_src = accept ? dwell : cfg_dwell;
    reload_val = (reload_src == '0) ? '0 : reload_src - DWELL_W'(1);
    lfsr_en    = (nxt_ph == PH_ENTROPY);
  end

  ew_lfsr8 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .enable (lfsr_en),
    .value  (lfsr_value)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_ph      <= PH_IDLE;
      phase       <= 3'd0;
      dwell_cnt   <= '0;
      cfg_dwell   <= '0;
      cfg_mask    <= 4'd0;
      cfg_repeat  <= 1'b0;
      signal_out  <= SIG_IDLE;
      command_out <= CMD_IDLE;
      valid       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (accept) begin
        cfg_mask   <= scenario_mask;
        cfg_dwell  <= dwell;
        cfg_repeat <= repeat_en;
      end

      cur_ph <= nxt_ph;
      phase  <= nxt_ph;

      if (nxt_ph == PH_IDLE)     dwell_cnt <= '0;
      else if (nxt_ph != cur_ph) dwell_cnt <= reload_val;
      else                       dwell_cnt <= dwell_cnt - DWELL_W'(1);

      valid <= (nxt_ph == PH_BURST) || (nxt_ph == PH_SPOOF) ||
               (nxt_ph == PH_ENTROPY) || (nxt_ph == PH_SWEEP);
      busy  <= (nxt_ph != PH_IDLE);
      done  <= (nxt_ph == PH_DONE);

      case (nxt_ph)
        PH_BURST: begin
          signal_out  <= SIG_BURST;
          command_out <= CMD_BURST;
        end
        PH_SPOOF: begin
          signal_out  <= SIG_SPOOF;
          command_out <= CMD_SPOOF;
        end
        PH_ENTROPY: begin
          // show the value the LFSR is stepping to on this same edge
          signal_out  <= lfsr_step(lfsr_value);
          command_out <= CMD_ENTROPY;
        end
        PH_SWEEP: begin
          signal_out  <= (cur_ph == PH_SWEEP) ? signal_out + 8'd1 : 8'h00;
          command_out <= CMD_SWEEP;
        end
        default: begin
          signal_out  <= SIG_IDLE;
          command_out <= CMD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ew_threat_gen.sv
// tb/tb_ew_threat_gen.sv - self-checking bench for ew_threat_gen
module tb_ew_threat_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] scenario_mask = 4'd0;
  logic [7:0] dwell = 8'd0;
  logic       repeat_en = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] signal_out;
  logic [7:0] command_out;
  logic [2:0] phase;
  logic       valid;
  logic       busy;
  logic       done;

  ew_threat_gen #(.DWELL_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .scenario_mask (scenario_mask),
    .dwell         (dwell),
    .repeat_en     (repeat_en),
    .abort         (abort),
    .signal_out    (signal_out),
    .command_out   (command_out),
    .phase         (phase),
    .valid         (valid),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ph;
    int         idx;
  } exp_t;

  typedef struct {
    logic [3:0] m;
    int         d;
    logic [2:0] first_ph;
    int         busy_cyc;
    int         valid_cyc;
  } vec_t;

  exp_t       q[$];
  logic [7:0] m_lfsr;
  int         n_cmp = 0;
  int         n_fail = 0;

  function automatic logic [7:0] m_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // One scenario pass: enabled threats ascending, QUIET, then one DONE cycle
  task automatic push_pass(input logic [3:0] m, input int d);
    int eff;
    eff = (d == 0) ? 1 : d;
    for (int b = 0; b < 4; b++)
      if (m[b])
        for (int k = 0; k < eff; k++) q.push_back('{ph: 3'(b + 1), idx: k});
    for (int k = 0; k < eff; k++) q.push_back('{ph: 3'd5, idx: k});
    q.push_back('{ph: 3'd6, idx: 0});
  endtask

  task automatic cmp(input string name, input logic [2:0] eph, input logic [7:0] esig,
                     input logic [7:0] ecmd, input logic ev, input logic eb, input logic ed);
    n_cmp++;
    if ({phase, signal_out, command_out, valid, busy, done} !== {eph, esig, ecmd, ev, eb, ed}) begin
      n_fail++;
      $display("FAIL %s: got ph=%0d sig=%02h cmd=%02h v=%b b=%b d=%b, want ph=%0d sig=%02h cmd=%02h v=%b b=%b d=%b",
               name, phase, signal_out, command_out, valid, busy, done, eph, esig, ecmd, ev, eb, ed);
    end
  endtask

  task automatic check_idle(input string name);
    cmp(name, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_next(input string name);
    exp_t       e;
    logic [7:0] s;
    logic [7:0] c;
    e = q.pop_front();
    case (e.ph)
      3'd1: begin s = 8'd220; c = 8'hFF; end
      3'd2: begin s = 8'd123; c = 8'h00; end
      3'd3: begin m_lfsr = m_step(m_lfsr); s = m_lfsr; c = 8'hAA; end
      3'd4: begin s = 8'(e.idx); c = 8'h55; end
      default: begin s = 8'h00; c = 8'h00; end
    endcase
    cmp(name, e.ph, s, c, (e.ph >= 3'd1) && (e.ph <= 3'd4), 1'b1, e.ph == 3'd6);
  endtask

  // Pulse start; returns at the sampling point of the first scenario cycle
  task automatic kick(input logic [3:0] m, input int d, input logic r);
    @(negedge clk);
    scenario_mask = m;
    dwell = 8'(d);
    repeat_en = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scenario_mask = 4'($urandom);
    dwell = 8'($urandom);
    repeat_en = 1'($urandom);
  endtask

  task automatic play(input string name, output int bc, output int vc);
    bc = 0;
    vc = 0;
    while (q.size() > 0) begin
      bc += int'(busy);
      vc += int'(valid);
      check_next(name);
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t vt[7];
    int   bc;
    int   vc;
    logic [3:0] rm;
    int   rd;
    logic rr;

    vt[0] = '{m: 4'b0001, d: 3,   first_ph: 3'd1, busy_cyc: 7,   valid_cyc: 3};
    vt[1] = '{m: 4'b1111, d: 2,   first_ph: 3'd1, busy_cyc: 11,  valid_cyc: 8};
    vt[2] = '{m: 4'b1000, d: 0,   first_ph: 3'd4, busy_cyc: 3,   valid_cyc: 1};
    vt[3] = '{m: 4'b0110, d: 4,   first_ph: 3'd2, busy_cyc: 13,  valid_cyc: 8};
    vt[4] = '{m: 4'b1000, d: 255, first_ph: 3'd4, busy_cyc: 511, valid_cyc: 255};
    vt[5] = '{m: 4'b0101, d: 1,   first_ph: 3'd1, busy_cyc: 4,   valid_cyc: 2};
    vt[6] = '{m: 4'b0010, d: 5,   first_ph: 3'd2, busy_cyc: 11,  valid_cyc: 5};

    m_lfsr = 8'hE1;
    @(negedge clk);
    check_idle("reset_hold");
    @(negedge clk);
    check_idle("reset_hold2");
    reset = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    for (int i = 0; i < 7; i++) begin
      push_pass(vt[i].m, vt[i].d);
      kick(vt[i].m, vt[i].d, 1'b0);
      n_cmp++;
      if (phase !== vt[i].first_ph) begin
        n_fail++;
        $display("FAIL vec%0d_first_phase: got %0d want %0d", i, phase, vt[i].first_ph);
      end
      play($sformatf("vec%0d_cycle", i), bc, vc);
      n_cmp++;
      if (bc != vt[i].busy_cyc || vc != vt[i].valid_cyc) begin
        n_fail++;
        $display("FAIL vec%0d_counts: got busy=%0d valid=%0d want busy=%0d valid=%0d",
                 i, bc, vc, vt[i].busy_cyc, vt[i].valid_cyc);
      end
      check_idle($sformatf("vec%0d_end", i));
    end

    // Repeat loop, then abort during the second SPOOF
    push_pass(4'b0110, 4);
    push_pass(4'b0110, 4);
    kick(4'b0110, 4, 1'b1);
    for (int k = 0; k < 15; k++) begin
      check_next("repeat_cycle");
      @(negedge clk);
    end
    check_next("repeat_spoof2");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    q.delete();
    for (int k = 0; k < 3; k++) begin
      check_idle("after_abort");
      @(negedge clk);
    end

    // Ignored starts: empty mask, start with abort, start while busy
    scenario_mask = 4'd0; dwell = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_idle("start_mask0");
    scenario_mask = 4'hF; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_idle("start_abort");
    @(negedge clk);
    check_idle("start_abort2");
    push_pass(4'b0001, 3);
    kick(4'b0001, 3, 1'b0);
    check_next("busy_start");
    start = 1'b1; scenario_mask = 4'hF; dwell = 8'd1;
    @(negedge clk);
    start = 1'b0;
    play("busy_start", bc, vc);
    check_idle("busy_start_end");

    // Asynchronous reset in the middle of ENTROPY
    push_pass(4'b0100, 4);
    kick(4'b0100, 4, 1'b0);
    check_next("pre_reset_entropy");
    @(negedge clk);
    check_next("pre_reset_entropy");
    #2 reset = 1'b0;
    #1 check_idle("async_reset");
    q.delete();
    m_lfsr = 8'hE1;
    @(negedge clk);
    reset = 1'b1;
    scenario_mask = 4'b0100; dwell = 8'd2; repeat_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmp("reseed_byte0", 3'd3, 8'hC2, 8'hAA, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    cmp("reseed_byte1", 3'd3, 8'h85, 8'hAA, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    m_lfsr = m_step(m_step(8'hE1));
    push_pass(4'b0100, 2);
    void'(q.pop_front());
    void'(q.pop_front());
    play("reseed_tail", bc, vc);
    check_idle("reseed_end");

    // Randomized scenarios against the reference model
    for (int n = 0; n < 20; n++) begin
      rm = 4'($urandom_range(1, 15));
      rd = $urandom_range(0, 5);
      rr = ($urandom_range(0, 3) == 0);
      push_pass(rm, rd);
      if (rr) push_pass(rm, rd);
      kick(rm, rd, rr);
      play($sformatf("rand%0d", n), bc, vc);
      if (rr) begin
        push_pass(rm, rd);
        check_next($sformatf("rand%0d_loop", n));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        q.delete();
      end
      check_idle($sformatf("rand%0d_end", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
